// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared types and helpers for the bubble_sort_stream sort engine.
//   sort_state_t  : controller states (IDLE -> SORT -> OUT -> IDLE)
//   SORT_MAX_W    : widest word the compare helper accepts; callers
//                   zero-extend narrower words up to this width
//   out_of_order  : compare rule shared by every compare-swap cell
// -----------------------------------------------------------------------------
package sort_pkg;

    localparam int SORT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } sort_state_t;

    // True when the pair (a, b) must be exchanged. Equal words never swap,
    // which is what keeps the odd-even transposition sort stable.
    function automatic logic out_of_order(
        input logic [SORT_MAX_W-1:0] a,
        input logic [SORT_MAX_W-1:0] b,
        input logic                  descend
    );
        logic res;
        if (descend) begin
            res = (a < b);
        end else begin
            res = (a > b);
        end
        return res;
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// -----------------------------------------------------------------------------
// sort_cmp_swap
// Combinational compare-exchange cell for one adjacent pair. The index tag of
// each word travels with it so the original position survives the sort.
//   a_i, b_i                    : words at the lower / upper position
//   tag_a_i, tag_b_i            : their original-index tags
//   descend_i                   : 0 = ascending, 1 = descending
//   first_o, second_o           : ordered pair (lower / upper position)
//   tag_first_o, tag_second_o   : tags following their words
// DATA_W must not exceed SORT_MAX_W.
// -----------------------------------------------------------------------------
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [IDX_W-1:0]  tag_a_i,
    input  logic [IDX_W-1:0]  tag_b_i,
    input  logic              descend_i,
    output logic [DATA_W-1:0] first_o,
    output logic [DATA_W-1:0] second_o,
    output logic [IDX_W-1:0]  tag_first_o,
    output logic [IDX_W-1:0]  tag_second_o
);

    logic [SORT_MAX_W-1:0] a_ext_s;
    logic [SORT_MAX_W-1:0] b_ext_s;
    logic                  swap_s;

    assign a_ext_s = SORT_MAX_W'(a_i);
    assign b_ext_s = SORT_MAX_W'(b_i);
    assign swap_s  = out_of_order(a_ext_s, b_ext_s, descend_i);

    // Exchange the pair (and its tags) only when it is out of order.
    always_comb begin
        if (swap_s) begin
            first_o      = b_i;
            second_o     = a_i;
            tag_first_o  = tag_b_i;
            tag_second_o = tag_a_i;
        end else begin
            first_o      = a_i;
            second_o     = b_i;
            tag_first_o  = tag_a_i;
            tag_second_o = tag_b_i;
        end
    end

endmodule

// File: rtl/bubble_sort_stream.sv
// -----------------------------------------------------------------------------
// bubble_sort_stream
// Captures DATA_N unsigned words in parallel, sorts them in place with DATA_N
// odd-even transposition passes (one per cycle), then streams them out one
// word per valid/ready handshake, each tagged with its original index.
//   clk, rst_n        : clock, asynchronous active-low reset
//   data_in[0:N-1]    : words to sort, sampled with an accepted start_sort
//   start_sort        : single-cycle request, accepted only in IDLE
//   descend           : sort order sampled with start_sort (1 = descending)
//   busy              : high while sorting or streaming
//   out_vld/out_rdy   : output handshake
//   data_out, idx_out : current sorted word and its original position
//   out_last          : marks the final word of the stream
// All outputs come straight from flops; out_rdy only feeds next-state logic.
// -----------------------------------------------------------------------------
module bubble_sort_stream
    import sort_pkg::*;
#(
    parameter int DATA_N = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(DATA_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in [0:DATA_N-1],
    input  logic              start_sort,
    input  logic              descend,
    output logic              busy,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] data_out,
    output logic [IDX_W-1:0]  idx_out,
    output logic              out_last
);

    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA_N - 1);

    sort_state_t       state_q, state_d;

    logic [DATA_W-1:0] arr_q [0:DATA_N-1];
    logic [DATA_W-1:0] arr_d [0:DATA_N-1];
    logic [IDX_W-1:0]  tag_q [0:DATA_N-1];
    logic [IDX_W-1:0]  tag_d [0:DATA_N-1];

    // Results of the even-pairing and odd-pairing passes over arr_q.
    logic [DATA_W-1:0] even_arr_s [0:DATA_N-1];
    logic [IDX_W-1:0]  even_tag_s [0:DATA_N-1];
    logic [DATA_W-1:0] odd_arr_s  [0:DATA_N-1];
    logic [IDX_W-1:0]  odd_tag_s  [0:DATA_N-1];

    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  ptr_q, ptr_d;
    logic              descend_q, descend_d;
    logic [IDX_W-1:0]  rd_idx_s;

    logic              busy_q, busy_d;
    logic              out_vld_q, out_vld_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [IDX_W-1:0]  idx_out_q, idx_out_d;

    // ------------------------------------------------------------------
    // Even bank: pairs (0,1),(2,3),...; odd DATA_N leaves the top untouched.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < DATA_N / 2; p++) begin : g_even
        sort_cmp_swap #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
            .a_i          (arr_q[2*p]),
            .b_i          (arr_q[2*p+1]),
            .tag_a_i      (tag_q[2*p]),
            .tag_b_i      (tag_q[2*p+1]),
            .descend_i    (descend_q),
            .first_o      (even_arr_s[2*p]),
            .second_o     (even_arr_s[2*p+1]),
            .tag_first_o  (even_tag_s[2*p]),
            .tag_second_o (even_tag_s[2*p+1])
        );
    end
    if (DATA_N % 2 == 1) begin : g_even_tail
        assign even_arr_s[DATA_N-1] = arr_q[DATA_N-1];
        assign even_tag_s[DATA_N-1] = tag_q[DATA_N-1];
    end

    // ------------------------------------------------------------------
    // Odd bank: pairs (1,2),(3,4),...; element 0 always passes through,
    // and so does the top element when DATA_N is even.
    // ------------------------------------------------------------------
    assign odd_arr_s[0] = arr_q[0];
    assign odd_tag_s[0] = tag_q[0];
    for (genvar p = 0; p < (DATA_N - 1) / 2; p++) begin : g_odd
        sort_cmp_swap #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
            .a_i          (arr_q[2*p+1]),
            .b_i          (arr_q[2*p+2]),
            .tag_a_i      (tag_q[2*p+1]),
            .tag_b_i      (tag_q[2*p+2]),
            .descend_i    (descend_q),
            .first_o      (odd_arr_s[2*p+1]),
            .second_o     (odd_arr_s[2*p+2]),
            .tag_first_o  (odd_tag_s[2*p+1]),
            .tag_second_o (odd_tag_s[2*p+2])
        );
    end
    if (DATA_N % 2 == 0) begin : g_odd_tail
        assign odd_arr_s[DATA_N-1] = arr_q[DATA_N-1];
        assign odd_tag_s[DATA_N-1] = tag_q[DATA_N-1];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_sort) begin
                    state_d = SORT;
                end else begin
                    state_d = IDLE;
                end
            end
            SORT: begin
                if (pass_cnt_q == LAST_POS) begin
                    state_d = OUT;
                end else begin
                    state_d = SORT;
                end
            end
            OUT: begin
                // out_vld is high throughout OUT, so out_rdy alone is the handshake.
                if (out_rdy && (ptr_q == LAST_POS)) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next-state: capture, one transposition pass, or pointer advance.
    always_comb begin
        arr_d      = arr_q;
        tag_d      = tag_q;
        pass_cnt_d = pass_cnt_q;
        ptr_d      = ptr_q;
        descend_d  = descend_q;
        case (state_q)
            IDLE: begin
                if (start_sort) begin
                    for (int i = 0; i < DATA_N; i++) begin
                        arr_d[i] = data_in[i];
                        tag_d[i] = IDX_W'(i);
                    end
                    descend_d  = descend;
                    pass_cnt_d = {CNT_W{1'b0}};
                    ptr_d      = {CNT_W{1'b0}};
                end else begin
                    descend_d = descend_q;
                end
            end
            SORT: begin
                // Pass parity picks which pairing bank is written back.
                if (pass_cnt_q[0]) begin
                    arr_d = odd_arr_s;
                    tag_d = odd_tag_s;
                end else begin
                    arr_d = even_arr_s;
                    tag_d = even_tag_s;
                end
                pass_cnt_d = pass_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                ptr_d      = {CNT_W{1'b0}};
            end
            OUT: begin
                if (out_rdy) begin
                    ptr_d = ptr_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                ptr_d = {CNT_W{1'b0}};
            end
        endcase
    end

    assign rd_idx_s = ptr_d[IDX_W-1:0];

    // FSM output logic: next values of the output flops. Reading arr_d/tag_d
    // lets the first word appear on the same edge that ends the last pass.
    always_comb begin
        busy_d    = (state_d != IDLE);
        out_vld_d = (state_d == OUT);
        if (state_d == OUT) begin
            data_out_d = arr_d[rd_idx_s];
            idx_out_d  = tag_d[rd_idx_s];
            out_last_d = (ptr_d == LAST_POS);
        end else begin
            data_out_d = {DATA_W{1'b0}};
            idx_out_d  = {IDX_W{1'b0}};
            out_last_d = 1'b0;
        end
    end

    // Datapath registers: word array, tags, counters and latched order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DATA_N; i++) begin
                arr_q[i] <= {DATA_W{1'b0}};
                tag_q[i] <= {IDX_W{1'b0}};
            end
            pass_cnt_q <= {CNT_W{1'b0}};
            ptr_q      <= {CNT_W{1'b0}};
            descend_q  <= 1'b0;
        end else begin
            arr_q      <= arr_d;
            tag_q      <= tag_d;
            pass_cnt_q <= pass_cnt_d;
            ptr_q      <= ptr_d;
            descend_q  <= descend_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            data_out_q <= {DATA_W{1'b0}};
            idx_out_q  <= {IDX_W{1'b0}};
        end else begin
            busy_q     <= busy_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            data_out_q <= data_out_d;
            idx_out_q  <= idx_out_d;
        end
    end

    assign busy     = busy_q;
    assign out_vld  = out_vld_q;
    assign out_last = out_last_q;
    assign data_out = data_out_q;
    assign idx_out  = idx_out_q;

endmodule

// File: doc/bubble_sort_stream.md
# bubble_sort_stream

Parametrised sort engine. It captures DATA_N unsigned words in parallel and sorts them in place with odd-even transposition passes, either ascending or descending. It then streams the result out one word per handshake, tagging each word with its original input index. It is the next-generation replacement for the fixed 4x4 sorter: a data-path block that sits between a parallel producer and a valid/ready serial consumer.

## Interface
- DATA_N, default 8: number of words per sort; legal range 2..256.
- DATA_W, default 8: word width in bits; unsigned compare.
- IDX_W, default $clog2(DATA_N): width of the index tag. Derived; do not override.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in[0:DATA_N-1]  in  DATA_W each  words to sort; sampled only with an accepted start_sort.
- start_sort  in  1  single-cycle request; accepted only in IDLE.
- descend  in  1  sort order, sampled with start_sort: 0 = ascending, 1 = descending.
- busy  out  1  high in SORT and OUT states.
- out_vld  out  1  output word valid.
- out_rdy  in  1  consumer ready.
- data_out  out  DATA_W  current sorted word.
- idx_out  out  IDX_W  original data_in position of data_out.
- out_last  out  1  high with the final word (position DATA_N-1).

## Operation
- FSM with three states:
  - IDLE: start_sort=1 latches data_in into arr[], loads tag[i]=i, latches descend, clears pass_cnt, moves to SORT.
  - SORT: one pass per cycle.
    - Even pass_cnt compares pairs (0,1),(2,3),…
    - Odd pass_cnt compares pairs (1,2),(3,4),…
    - Swap when out of order: ascending swaps if arr[i]>arr[i+1]; descending swaps if arr[i]<arr[i+1]. Equal words never swap, so the sort is stable.
    - Tags move with their data.
    - After pass_cnt reaches DATA_N-1, go to OUT with ptr=0.
  - OUT: out_vld=1, data_out=arr[ptr], idx_out=tag[ptr], out_last=(ptr==DATA_N-1).
    - On out_vld&&out_rdy, ptr increments.
    - On the handshake with out_last, return to IDLE.
- start_sort outside IDLE is ignored; there is no queueing and no error flag.
- start_sort in the same cycle as the final handshake is ignored.
- data_in and descend changes outside an accepted start have no effect.
- pass_cnt and ptr are IDX_W+1 bits wide with no wrap: the FSM leaves the state before overflow.
- Odd DATA_N: the unpaired end element is untouched in that pass.
- Reset (any state, asynchronous): state=IDLE; busy, out_vld, out_last, data_out, idx_out = 0; arr, tag, ptr, pass_cnt = 0. An in-flight sort is discarded.

## Timing
- start_sort high at rising edge E0. Then:
  - busy=1 after E0.
  - SORT occupies the cycles following edges E0..E0+DATA_N-1, exactly DATA_N passes.
  - out_vld=1 after E0+DATA_N.
- Fixed latency from start to first out_vld: DATA_N cycles.
- Minimum total occupancy: 2*DATA_N cycles. Start-to-start minimum: 2*DATA_N+1 cycles.
- Backpressure: data_out, idx_out and out_last are held stable while out_vld && !out_rdy.
- out_vld never drops before its handshake.
- All outputs are registered or decoded from registered state only; there is no combinational path from out_rdy to any output.
- After the last handshake: out_vld=0 and busy=0 in the next cycle.

## Structure
- Package sort_pkg holds:
  - sort_state_t enum {IDLE, SORT, OUT};
  - function out_of_order(a, b, descend) for the compare rule.
- Sub-module sort_cmp_swap (one per pair, generate loop) takes a, b, tag_a, tag_b, descend and returns the ordered pair combinationally.
- The top holds the FSM, counters and register array; pairing selection per pass is done by two generate banks muxed on pass_cnt[0].

## Test plan
- Ascending, DATA_N=8, DATA_W=8, input {7,3,9,1,8,2,6,0}, out_rdy=1 -> first out_vld 8 cycles after start; data_out 0,1,2,3,6,7,8,9; idx_out 7,3,5,1,6,0,4,2; out_last only on the 9.
- Descending with duplicates, input {5,5,1,9,5,0,9,2} -> data_out 9,9,5,5,5,2,1,0; idx_out 3,6,0,1,4,7,2,5 (stable).
- Backpressure: out_rdy toggles 1,0,0,1,… -> each word is held while stalled; exactly 8 handshakes; busy drops one cycle after the last handshake.
- start_sort pulsed during SORT and OUT, with different data_in -> ignored; output matches the first capture; a new start in IDLE is accepted.
- rst_n asserted mid-SORT (cycle 3) and mid-OUT (after 2 words) -> outputs 0 immediately; FSM returns to IDLE; the next start sorts fresh data correctly.
- DATA_N=5, DATA_W=4, already-sorted {0,1,2,3,15} and reverse {15,3,2,1,0} -> both yield 0,1,2,3,15; the odd-length unpaired element is handled.
